watch_window_memory: RTL and testbench

- Byte-strobed word memory of pWords words; the top pWatchWords words form a watch window.
- Each watched word is mirrored in reset-able shadow registers, exposed as a flat bus.
- Every write touching the window raises a notification, delivered one at a time over a valid/ready event port with round-robin fairness.
- Sits between the core's store path and host-visible status/mailbox logic.

---
 rtl/watch_window_memory.sv | 161 ++++++++++++++++
 tb/tb_watch_window_memory.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_window_memory.sv
// Byte-strobed word memory whose top words are mirrored into shadows with
// round-robin change notifications. Optional power-on scrub: WATCH_INIT_EN.
module watch_window_memory #(
  parameter int pWords      = 44,
  parameter int pWatchWords = 4
) (
  input  logic                       iwClk,
  input  logic                       iwRst,
  input  logic [31:0]                iwReadAddr,
  input  logic [31:0]                iwWriteAddr,
  input  logic [31:0]                iwWriteData,
  input  logic [3:0]                 iwWstrb,
  output logic [31:0]                owReadData,
  output logic [32*pWatchWords-1:0]  owWatchData,
  output logic                       owEvtValid,
  output logic [7:0]                 owEvtIndex,
  input  logic                       iwEvtReady,
  output logic                       owBusy
);

  localparam int AW = (pWords > 1) ? $clog2(pWords) : 1;
  localparam logic [29:0] WORDS = 30'(pWords);
  localparam logic [29:0] BASE  = 30'(pWords - pWatchWords);
  localparam logic [7:0]  LAST  = 8'(pWatchWords - 1);

  logic [31:0] mem [pWords];
  logic [pWatchWords-1:0][31:0] shadow;
  logic [pWatchWords-1:0] dirty;
  logic [pWatchWords-1:0] dirty_n;
  logic [7:0] ptr;

  logic [29:0] rd_idx;
  logic [29:0] wr_idx;
  logic        busy;
  logic        wr_en;
  logic        win_hit;
  logic [7:0]  win_idx;

  assign rd_idx  = iwReadAddr[31:2];
  assign wr_idx  = iwWriteAddr[31:2];
  assign wr_en   = (|iwWstrb) && (wr_idx < WORDS) && !busy;
  assign win_hit = wr_en && (wr_idx >= BASE);
  assign win_idx = 8'(wr_idx - BASE);

  logic unused_addr;
  assign unused_addr = ^{iwReadAddr[1:0], iwWriteAddr[1:0]};

`ifdef WATCH_INIT_EN
  typedef enum logic {SCRUB, IDLE} state_t;
  state_t         state;
  logic [AW-1:0]  scrub_idx;

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state     <= SCRUB;
      scrub_idx <= '0;
      busy      <= 1'b1;
    end else begin
      unique case (state)
        SCRUB: begin
          if (scrub_idx == AW'(pWords - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            scrub_idx <= scrub_idx + 1'b1;
          end
        end
        IDLE: busy <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge iwClk) begin
    if (busy) begin
      mem[scrub_idx] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (iwWstrb[b])
          mem[wr_idx[AW-1:0]][8*b +: 8] <= iwWriteData[8*b +: 8];
    end
  end
`else
  assign busy = 1'b0;

  always_ff @(posedge iwClk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (iwWstrb[b])
          mem[wr_idx[AW-1:0]][8*b +: 8] <= iwWriteData[8*b +: 8];
    end
  end
`endif

  assign owBusy      = busy;
  assign owWatchData = shadow;

  always_comb begin
    owReadData = '0;
    if (!busy && rd_idx < WORDS)
      owReadData = mem[rd_idx[AW-1:0]];
  end

  // Round-robin: prefer the lowest dirty index at or above ptr, else wrap.
  logic       hi_found;
  logic [7:0] hi_idx;
  logic [7:0] lo_idx;
  logic [7:0] pick;
  logic       load;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int w = pWatchWords - 1; w >= 0; w--) begin
      if (dirty[w] && 8'(w) >= ptr) begin
        hi_found = 1'b1;
        hi_idx   = 8'(w);
      end
      if (dirty[w])
        lo_idx = 8'(w);
    end
    pick = hi_found ? hi_idx : lo_idx;
  end

  assign load = (!owEvtValid || iwEvtReady) && (|dirty);

  // A write landing on the word being loaded keeps it dirty.
  always_comb begin
    dirty_n = dirty;
    for (int w = 0; w < pWatchWords; w++) begin
      if (load && 8'(w) == pick)
        dirty_n[w] = 1'b0;
      if (win_hit && 8'(w) == win_idx)
        dirty_n[w] = 1'b1;
    end
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      shadow     <= '0;
      dirty      <= '0;
      ptr        <= '0;
      owEvtValid <= 1'b0;
      owEvtIndex <= '0;
    end else begin
      dirty <= dirty_n;
      for (int w = 0; w < pWatchWords; w++)
        for (int b = 0; b < 4; b++)
          if (win_hit && 8'(w) == win_idx && iwWstrb[b])
            shadow[w][8*b +: 8] <= iwWriteData[8*b +: 8];
      if (load) begin
        owEvtValid <= 1'b1;
        owEvtIndex <= pick;
        ptr        <= (pick == LAST) ? 8'd0 : pick + 8'd1;
      end else if (owEvtValid && iwEvtReady) begin
        owEvtValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_watch_window_memory.sv
// Directed self-checking bench for watch_window_memory (pWords=44,
// pWatchWords=4); the scrub scenario is built only with WATCH_INIT_EN.
module tb_watch_window_memory;

  logic         iwClk = 1'b0;
  logic         iwRst = 1'b1;
  logic [31:0]  iwReadAddr = '0;
  logic [31:0]  iwWriteAddr = '0;
  logic [31:0]  iwWriteData = '0;
  logic [3:0]   iwWstrb = '0;
  logic [31:0]  owReadData;
  logic [127:0] owWatchData;
  logic         owEvtValid;
  logic [7:0]   owEvtIndex;
  logic         iwEvtReady = 1'b0;
  logic         owBusy;

  int checks = 0;
  int failures = 0;

`ifdef WATCH_INIT_EN
  localparam logic EXP_BUSY = 1'b1;
`else
  localparam logic EXP_BUSY = 1'b0;
`endif

  localparam logic [127:0] FINAL_WATCH =
    {32'h55667788, 32'h9A345678, 32'hFF020304, 32'hA0A0BB01};

  watch_window_memory #(.pWords(44), .pWatchWords(4)) dut (
    .iwClk(iwClk),
    .iwRst(iwRst),
    .iwReadAddr(iwReadAddr),
    .iwWriteAddr(iwWriteAddr),
    .iwWriteData(iwWriteData),
    .iwWstrb(iwWstrb),
    .owReadData(owReadData),
    .owWatchData(owWatchData),
    .owEvtValid(owEvtValid),
    .owEvtIndex(owEvtIndex),
    .iwEvtReady(iwEvtReady),
    .owBusy(owBusy)
  );

  always #5 iwClk = ~iwClk;

  task automatic tick();
    @(posedge iwClk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    iwWriteAddr = a;
    iwWriteData = d;
    iwWstrb = s;
    tick();
    iwWstrb = '0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (owBusy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (owBusy !== 1'b0) begin
      $display("FAIL idle_timeout busy=%b want=0", owBusy); failures++;
    end
  endtask

  task automatic test_reset();
    iwRst = 1'b1;
    tick();
    checks++;
    if (owWatchData !== '0) begin
      $display("FAIL rst_watch got=%h want=0", owWatchData); failures++;
    end
    checks++;
    if (owEvtValid !== 1'b0 || owEvtIndex !== 8'd0) begin
      $display("FAIL rst_evt got=%b/%0d want=0/0", owEvtValid, owEvtIndex);
      failures++;
    end
    checks++;
    if (owBusy !== EXP_BUSY) begin
      $display("FAIL rst_busy got=%b want=%b", owBusy, EXP_BUSY); failures++;
    end
    iwRst = 1'b0;
    wait_idle();
  endtask

  task automatic test_mem();
    wr(32'h10, 32'hDEADBEEF, 4'hF);
    iwReadAddr = 32'h10;
    #1;
    checks++;
    if (owReadData !== 32'hDEADBEEF) begin
      $display("FAIL mem_full got=%h want=deadbeef", owReadData); failures++;
    end
    checks++;
    if (owWatchData !== '0 || owEvtValid !== 1'b0) begin
      $display("FAIL mem_nowatch got=%h/%b want=0/0", owWatchData, owEvtValid);
      failures++;
    end
    iwWriteAddr = 32'h10;
    iwWriteData = 32'hCAFEF00D;
    iwWstrb = 4'hF;
    #1;
    checks++;
    if (owReadData !== 32'hDEADBEEF) begin
      $display("FAIL mem_rdw_old got=%h want=deadbeef", owReadData); failures++;
    end
    tick();
    iwWstrb = '0;
    checks++;
    if (owReadData !== 32'hCAFEF00D) begin
      $display("FAIL mem_rdw_new got=%h want=cafef00d", owReadData); failures++;
    end
    wr(32'h13, 32'h11223344, 4'b0101);
    iwReadAddr = 32'h11;
    #1;
    checks++;
    if (owReadData !== 32'hCA22F044) begin
      $display("FAIL mem_strobe got=%h want=ca22f044", owReadData); failures++;
    end
  endtask

  task automatic test_window();
    iwEvtReady = 1'b0;
    wr(32'hAC, 32'h11223344, 4'b0101);
    checks++;
    if (owWatchData[127:96] !== 32'h00220044 || owEvtValid !== 1'b0) begin
      $display("FAIL win_shadow got=%h/%b want=00220044/0",
               owWatchData[127:96], owEvtValid);
      failures++;
    end
    tick();
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd3) begin
      $display("FAIL win_evt got=%b/%0d want=1/3", owEvtValid, owEvtIndex);
      failures++;
    end
    iwReadAddr = 32'hAC;
    #1;
    checks++;
    if (owReadData[23:16] !== 8'h22 || owReadData[7:0] !== 8'h44) begin
      $display("FAIL win_mem got=%h want=xx22xx44", owReadData); failures++;
    end
    iwEvtReady = 1'b1;
    tick();
    checks++;
    if (owEvtValid !== 1'b0) begin
      $display("FAIL win_accept got=%b want=0", owEvtValid); failures++;
    end
  endtask

  task automatic test_stall();
    iwEvtReady = 1'b0;
    wr(32'hA0, 32'hA0A0A0A0, 4'hF);
    wr(32'hA8, 32'h12345678, 4'hF);
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd0) begin
      $display("FAIL stall_first got=%b/%0d want=1/0", owEvtValid, owEvtIndex);
      failures++;
    end
    wr(32'hA8, 32'h9ABCDEF0, 4'b1000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd0) begin
        $display("FAIL stall_hold%0d got=%b/%0d want=1/0", i,
                 owEvtValid, owEvtIndex);
        failures++;
      end
    end
    iwEvtReady = 1'b1;
    tick();
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd2) begin
      $display("FAIL stall_second got=%b/%0d want=1/2", owEvtValid, owEvtIndex);
      failures++;
    end
    tick();
    checks++;
    if (owEvtValid !== 1'b0) begin
      $display("FAIL stall_merge got=%b want=0", owEvtValid); failures++;
    end
    checks++;
    if (owWatchData[95:64] !== 32'h9A345678 ||
        owWatchData[31:0] !== 32'hA0A0A0A0) begin
      $display("FAIL stall_shadow got=%h want=9a345678_xxxxxxxx_a0a0a0a0",
               owWatchData[95:0]);
      failures++;
    end
  endtask

  task automatic test_wrap();
    iwEvtReady = 1'b0;
    wr(32'hA0, 32'h00000001, 4'b0001);
    wr(32'hAC, 32'h55667788, 4'hF);
    wr(32'hA0, 32'h0000BB00, 4'b0010);
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd0) begin
      $display("FAIL wrap_pend got=%b/%0d want=1/0", owEvtValid, owEvtIndex);
      failures++;
    end
    iwEvtReady = 1'b1;
    tick();
    checks++;
    if (owEvtIndex !== 8'd3 || owEvtValid !== 1'b1) begin
      $display("FAIL wrap_first got=%b/%0d want=1/3", owEvtValid, owEvtIndex);
      failures++;
    end
    tick();
    checks++;
    if (owEvtIndex !== 8'd0 || owEvtValid !== 1'b1) begin
      $display("FAIL wrap_second got=%b/%0d want=1/0", owEvtValid, owEvtIndex);
      failures++;
    end
    tick();
    checks++;
    if (owEvtValid !== 1'b0) begin
      $display("FAIL wrap_drain got=%b want=0", owEvtValid); failures++;
    end
  endtask

  task automatic test_same_edge();
    iwEvtReady = 1'b0;
    wr(32'hA4, 32'h01020304, 4'hF);
    wr(32'hA4, 32'hFF000000, 4'b1000);
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd1) begin
      $display("FAIL same_load got=%b/%0d want=1/1", owEvtValid, owEvtIndex);
      failures++;
    end
    iwEvtReady = 1'b1;
    tick();
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd1) begin
      $display("FAIL same_reissue got=%b/%0d want=1/1", owEvtValid, owEvtIndex);
      failures++;
    end
    tick();
    checks++;
    if (owEvtValid !== 1'b0) begin
      $display("FAIL same_drain got=%b want=0", owEvtValid); failures++;
    end
    checks++;
    if (owWatchData !== FINAL_WATCH) begin
      $display("FAIL same_watch got=%h want=%h", owWatchData, FINAL_WATCH);
      failures++;
    end
  endtask

  task automatic test_out_of_range();
    iwEvtReady = 1'b1;
    wr(32'hB0, 32'hFFFFFFFF, 4'hF);
    wr(32'hAC, 32'hFFFFFFFF, 4'h0);
    tick();
    checks++;
    if (owEvtValid !== 1'b0 || owWatchData !== FINAL_WATCH) begin
      $display("FAIL oor_window got=%b/%h want=0/%h", owEvtValid,
               owWatchData, FINAL_WATCH);
      failures++;
    end
    iwReadAddr = 32'hB0;
    #1;
    checks++;
    if (owReadData !== 32'h0) begin
      $display("FAIL oor_read got=%h want=0", owReadData); failures++;
    end
    iwReadAddr = 32'hFFFFFFFC;
    #1;
    checks++;
    if (owReadData !== 32'h0) begin
      $display("FAIL oor_read_top got=%h want=0", owReadData); failures++;
    end
    iwReadAddr = 32'h10;
    #1;
    checks++;
    if (owReadData !== 32'hCA22F044) begin
      $display("FAIL oor_mem got=%h want=ca22f044", owReadData); failures++;
    end
  endtask

  task automatic test_reset_mid();
    iwEvtReady = 1'b0;
    wr(32'hAC, 32'h0, 4'b0001);
    wr(32'hA4, 32'h0, 4'b0001);
    checks++;
    if (owEvtValid !== 1'b1 || owEvtIndex !== 8'd3) begin
      $display("FAIL mid_pend got=%b/%0d want=1/3", owEvtValid, owEvtIndex);
      failures++;
    end
    iwRst = 1'b1;
    #1;
    checks++;
    if (owEvtValid !== 1'b0 || owEvtIndex !== 8'd0 || owWatchData !== '0) begin
      $display("FAIL mid_async got=%b/%0d/%h want=0/0/0", owEvtValid,
               owEvtIndex, owWatchData);
      failures++;
    end
    tick();
    iwRst = 1'b0;
    wait_idle();
    iwEvtReady = 1'b1;
    tick();
    tick();
    checks++;
    if (owEvtValid !== 1'b0) begin
      $display("FAIL mid_dirty got=%b want=0", owEvtValid); failures++;
    end
  endtask

`ifdef WATCH_INIT_EN
  task automatic test_scrub();
    int n;
    iwEvtReady = 1'b0;
    iwRst = 1'b1;
    tick();
    iwRst = 1'b0;
    iwReadAddr = 32'h10;
    iwWriteAddr = 32'hAC;
    iwWriteData = 32'h12345678;
    iwWstrb = 4'hF;
    n = 0;
    while (owBusy === 1'b1 && n < 200) begin
      checks++;
      if (owReadData !== 32'h0) begin
        $display("FAIL scrub_read got=%h want=0", owReadData); failures++;
      end
      tick();
      n++;
    end
    iwWstrb = '0;
    checks++;
    if (n != 44) begin
      $display("FAIL scrub_len got=%0d want=44", n); failures++;
    end
    for (int a = 0; a < 44; a += 11) begin
      iwReadAddr = 32'(a * 4);
      #1;
      checks++;
      if (owReadData !== 32'h0) begin
        $display("FAIL scrub_zero%0d got=%h want=0", a, owReadData); failures++;
      end
    end
    iwReadAddr = 32'hAC;
    tick();
    checks++;
    if (owReadData !== 32'h0 || owWatchData !== '0 || owEvtValid !== 1'b0) begin
      $display("FAIL scrub_ignore got=%h/%h/%b want=0/0/0", owReadData,
               owWatchData, owEvtValid);
      failures++;
    end
    iwRst = 1'b1;
    tick();
    iwRst = 1'b0;
    repeat (20) tick();
    iwRst = 1'b1;
    #2;
    iwRst = 1'b0;
    n = 0;
    while (owBusy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != 44) begin
      $display("FAIL scrub_restart got=%0d want=44", n); failures++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mem();
    test_window();
    test_stall();
    test_wrap();
    test_same_edge();
    test_out_of_range();
    test_reset_mid();
`ifdef WATCH_INIT_EN
    test_scrub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
